// File: rtl/vend_fsm_multi.sv
// -----------------------------------------------------------------------------
// vend_fsm_multi
//   Multi-product vending controller. Credit is collected from 5/10/20 rs
//   coins and counted in 5 rs units. A selection is checked against a packed
//   per-product price table. The product is dispensed through a valid/ready
//   handshake. Any remaining credit is then paid out one coin per handshake,
//   largest coin first. A cancel in CREDIT refunds the whole credit the same
//   way.
//
// Ports
//   clk, rst       clock (rising edge), synchronous active-high reset
//   coin_valid     coin present this cycle; coin_type 00=5, 01=10, 10=20,
//                  11=invalid
//   coin_accept    one-cycle pulse: coin kept
//   coin_reject    one-cycle pulse: coin returned
//   sel_valid      product selection strobe; sel_id selects the product
//   sel_nack       one-cycle pulse: selection refused
//   cancel         refund request strobe
//   vend_valid     dispense request; vend_id is the product being dispensed
//   vend_ready     dispenser accepted the product
//   change_valid   change coin request; change_coin 00=5, 01=10, 10=20
//   change_ready   hopper released the coin
//   credit         current credit in 5 rs units
//   busy           high in VEND or CHANGE
//   state_dbg      current FSM state (0=IDLE 1=CREDIT 2=VEND 3=CHANGE)
//
// Handshake rule for vend_* and change_*: a transfer happens on a rising edge
// where valid and ready are both high. Once valid is raised, it and its
// payload (vend_id / change_coin) stay constant until that edge. Ready may
// be high before valid without effect.
// -----------------------------------------------------------------------------
module vend_fsm_multi #(
  parameter int CREDIT_W   = 8,
  parameter int N_PROD     = 4,
  parameter int MAX_CREDIT = 40,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {8'd6, 8'd4, 8'd3, 8'd2}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  output logic                coin_accept,
  output logic                coin_reject,
  input  logic                sel_valid,
  input  logic [3:0]          sel_id,
  output logic                sel_nack,
  input  logic                cancel,
  output logic                vend_valid,
  output logic [3:0]          vend_id,
  input  logic                vend_ready,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  state_t state;

  assign state_dbg = state;

  // Largest change coin that does not exceed the given credit.
  function automatic logic [1:0] coin_for(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(4))      coin_for = 2'b10;
    else if (c >= CREDIT_W'(2)) coin_for = 2'b01;
    else                        coin_for = 2'b00;
  endfunction

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic                sel_ok;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] vend_price;
  logic [CREDIT_W-1:0] vend_rem;
  logic [CREDIT_W-1:0] chg_val;
  logic [CREDIT_W-1:0] chg_rem;
  logic                cancel_take;

  always_comb begin
    coin_val = '0;
    case (coin_type)
      2'b00:   coin_val = CREDIT_W'(1);
      2'b01:   coin_val = CREDIT_W'(2);
      2'b10:   coin_val = CREDIT_W'(4);
      default: coin_val = '0;
    endcase
    // One extra bit so the overflow check cannot wrap.
    coin_sum = {1'b0, credit} + {1'b0, coin_val};
    coin_ok  = (coin_type != 2'b11) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

    // The table lookup is a match loop, so an out-of-range sel_id never
    // indexes past the end of PRICES. It simply finds no product.
    sel_ok     = 1'b0;
    sel_price  = '0;
    vend_price = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel_id == 4'(i)) begin
        sel_ok    = 1'b1;
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
      if (vend_id == 4'(i)) begin
        vend_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
    sel_ok   = sel_ok && (credit >= sel_price);
    vend_rem = credit - vend_price;

    chg_val = '0;
    case (change_coin)
      2'b00:   chg_val = CREDIT_W'(1);
      2'b01:   chg_val = CREDIT_W'(2);
      2'b10:   chg_val = CREDIT_W'(4);
      default: chg_val = '0;
    endcase
    chg_rem = credit - chg_val;

    // A cancel only acts in CREDIT. In IDLE it is ignored, so it must not
    // block the selection or the coin.
    cancel_take = cancel && (state == S_CREDIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      credit       <= '0;
      coin_accept  <= 1'b0;
      coin_reject  <= 1'b0;
      sel_nack     <= 1'b0;
      vend_valid   <= 1'b0;
      vend_id      <= 4'd0;
      change_valid <= 1'b0;
      change_coin  <= 2'b00;
      busy         <= 1'b0;
    end else begin
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      sel_nack    <= 1'b0;

      case (state)
        S_IDLE, S_CREDIT: begin
          if (cancel_take) begin
            state        <= S_CHANGE;
            busy         <= 1'b1;
            change_valid <= 1'b1;
            change_coin  <= coin_for(credit);
            if (coin_valid) coin_reject <= 1'b1;
          end else if (sel_valid && sel_ok) begin
            state      <= S_VEND;
            busy       <= 1'b1;
            vend_valid <= 1'b1;
            vend_id    <= sel_id;
            if (coin_valid) coin_reject <= 1'b1;
          end else begin
            // A refused selection does not consume the cycle. A coin
            // arriving with it is still judged on its own merits.
            if (sel_valid) sel_nack <= 1'b1;
            if (coin_valid) begin
              if (coin_ok) begin
                credit      <= coin_sum[CREDIT_W-1:0];
                coin_accept <= 1'b1;
                state       <= S_CREDIT;
              end else begin
                coin_reject <= 1'b1;
              end
            end
          end
        end

        S_VEND: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (sel_valid)  sel_nack    <= 1'b1;
          if (vend_valid && vend_ready) begin
            credit     <= vend_rem;
            vend_valid <= 1'b0;
            if (vend_rem != '0) begin
              state        <= S_CHANGE;
              change_valid <= 1'b1;
              change_coin  <= coin_for(vend_rem);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        S_CHANGE: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (sel_valid)  sel_nack    <= 1'b1;
          if (change_valid && change_ready) begin
            credit <= chg_rem;
            if (chg_rem != '0) begin
              change_coin <= coin_for(chg_rem);
            end else begin
              change_valid <= 1'b0;
              state        <= S_IDLE;
              busy         <= 1'b0;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_fsm_multi.sv
// -----------------------------------------------------------------------------
// tb_vend_fsm_multi
//   Directed bench for vend_fsm_multi with the default price table:
//   product 0 = 2, product 1 = 3, product 2 = 4, product 3 = 6 (5 rs units).
//   Inputs change 1 time unit after a rising edge. Outputs are sampled
//   1 time unit after the edge that consumed those inputs.
// -----------------------------------------------------------------------------
module tb_vend_fsm_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       coin_accept;
  logic       coin_reject;
  logic       sel_valid = 1'b0;
  logic [3:0] sel_id = 4'd0;
  logic       sel_nack;
  logic       cancel = 1'b0;
  logic       vend_valid;
  logic [3:0] vend_id;
  logic       vend_ready = 1'b0;
  logic       change_valid;
  logic [1:0] change_coin;
  logic       change_ready = 1'b0;
  logic [7:0] credit;
  logic       busy;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_CREDIT = 2'd1, ST_VEND = 2'd2, ST_CHANGE = 2'd3;
  localparam logic [1:0] C5 = 2'b00, C10 = 2'b01, C20 = 2'b10, CBAD = 2'b11;

  vend_fsm_multi dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .coin_accept  (coin_accept),
    .coin_reject  (coin_reject),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .sel_nack     (sel_nack),
    .cancel       (cancel),
    .vend_valid   (vend_valid),
    .vend_id      (vend_id),
    .vend_ready   (vend_ready),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .change_ready (change_ready),
    .credit       (credit),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drop_coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [3:0] id);
    sel_valid = 1'b1;
    sel_id    = id;
    tick();
    sel_valid = 1'b0;
  endtask

  initial begin
    // reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_credit", credit, 0);
    check("rst_vend_valid", vend_valid, 0);
    check("rst_change_valid", change_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_coin_accept", coin_accept, 0);

    // 10 + 10 rs, buy product 2 (price 4): exact, no change
    drop_coin(C10);
    check("t1_acc1", coin_accept, 1);
    check("t1_credit2", credit, 2);
    check("t1_state_credit", state_dbg, ST_CREDIT);
    drop_coin(C10);
    check("t1_acc2", coin_accept, 1);
    check("t1_credit4", credit, 4);
    select(4'd2);
    check("t1_vend_valid", vend_valid, 1);
    check("t1_vend_id", vend_id, 2);
    check("t1_busy", busy, 1);
    check("t1_state_vend", state_dbg, ST_VEND);
    tick();
    check("t1_vend_hold", vend_valid, 1);
    check("t1_credit_hold", credit, 4);
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    check("t1_vend_done", vend_valid, 0);
    check("t1_credit0", credit, 0);
    check("t1_state_idle", state_dbg, ST_IDLE);
    check("t1_no_change", change_valid, 0);
    check("t1_busy_low", busy, 0);

    // 20 + 10 + 5 rs = 7, buy product 1 (price 3), change one 20 rs coin
    drop_coin(C20);
    drop_coin(C10);
    drop_coin(C5);
    check("t2_credit7", credit, 7);
    select(4'd1);
    check("t2_vend_id", vend_id, 1);
    drop_coin(C5);
    check("t2_vend_coin_rej", coin_reject, 1);
    check("t2_vend_coin_noacc", coin_accept, 0);
    check("t2_vend_credit", credit, 7);
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    check("t2_credit4", credit, 4);
    check("t2_state_change", state_dbg, ST_CHANGE);
    check("t2_change_valid", change_valid, 1);
    check("t2_change_coin", change_coin, C20);
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    check("t2_credit0", credit, 0);
    check("t2_change_done", change_valid, 0);
    check("t2_state_idle", state_dbg, ST_IDLE);

    // refused selections; a coin alongside a nacked selection still counts
    drop_coin(C5);
    check("t3_credit1", credit, 1);
    select(4'd3);
    check("t3_nack_price", sel_nack, 1);
    check("t3_credit_kept", credit, 1);
    check("t3_state_credit", state_dbg, ST_CREDIT);
    select(4'd5);
    check("t3_nack_range", sel_nack, 1);
    check("t3_no_vend", vend_valid, 0);
    sel_valid = 1'b1; sel_id = 4'd3; coin_valid = 1'b1; coin_type = C5;
    tick();
    sel_valid = 1'b0; coin_valid = 1'b0;
    check("t3_nack_with_coin", sel_nack, 1);
    check("t3_coin_with_nack", coin_accept, 1);
    check("t3_credit2", credit, 2);

    // bring credit to 7, cancel with a coin in the same cycle
    drop_coin(C20);
    drop_coin(C5);
    check("t4_credit7", credit, 7);
    cancel = 1'b1; coin_valid = 1'b1; coin_type = C5;
    tick();
    cancel = 1'b0; coin_valid = 1'b0;
    check("t4_cancel_coin_rej", coin_reject, 1);
    check("t4_state_change", state_dbg, ST_CHANGE);
    check("t4_change_valid", change_valid, 1);
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_coin", change_coin, C20);
      check("t4_stall_credit", credit, 7);
      tick();
    end
    change_ready = 1'b1;
    tick();
    check("t4_coin2", change_coin, C10);
    check("t4_credit3", credit, 3);
    tick();
    check("t4_coin3", change_coin, C5);
    check("t4_credit1", credit, 1);
    check("t4_valid3", change_valid, 1);
    tick();
    change_ready = 1'b0;
    check("t4_credit0", credit, 0);
    check("t4_change_done", change_valid, 0);
    check("t4_state_idle", state_dbg, ST_IDLE);

    // credit limit: 9 x 20 rs + 10 rs = 38
    for (int i = 0; i < 9; i++) drop_coin(C20);
    drop_coin(C10);
    check("t5_credit38", credit, 38);
    drop_coin(C20);
    check("t5_over_rej", coin_reject, 1);
    check("t5_over_credit", credit, 38);
    drop_coin(CBAD);
    check("t5_bad_rej", coin_reject, 1);
    check("t5_bad_noacc", coin_accept, 0);
    drop_coin(C10);
    check("t5_max_acc", coin_accept, 1);
    check("t5_credit40", credit, 40);
    drop_coin(C5);
    check("t5_full_rej", coin_reject, 1);
    check("t5_full_credit", credit, 40);

    // refund, selection while busy, then reset mid-CHANGE
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("t6_change_coin", change_coin, C20);
    select(4'd0);
    check("t6_busy_nack", sel_nack, 1);
    change_ready = 1'b1;
    tick();
    check("t6_credit36", credit, 36);
    check("t6_valid_high", change_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    change_ready = 1'b0;
    check("t6_rst_credit", credit, 0);
    check("t6_rst_change_valid", change_valid, 0);
    check("t6_rst_change_coin", change_coin, 0);
    check("t6_rst_state", state_dbg, ST_IDLE);
    check("t6_rst_busy", busy, 0);
    drop_coin(C5);
    check("t6_post_acc", coin_accept, 1);
    check("t6_post_credit", credit, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
